// File: rtl/regpairfile_pkg.sv
// Shared definitions for the register-pair file: pair operation codes and
// the default placement of the flag/accumulator registers and PSW pair.
package regpairfile_pkg;

    typedef enum logic [1:0] {
        PID_NONE = 2'b00,
        PID_INC  = 2'b01,
        PID_DEC  = 2'b10,
        PID_RSVD = 2'b11
    } pid_op_e;

    function automatic int default_flag(input int regcount);
        return regcount - 2;
    endfunction

    function automatic int default_accu(input int regcount);
        return regcount - 1;
    endfunction

    // The last pair index is PSW: {accumulator, flags}.
    function automatic int psw_pair(input int regcount);
        return regcount / 2 - 1;
    endfunction

endpackage

// File: rtl/regpairfile_pairincdec.sv
// Pair-wide +1/-1 unit for INX/DCX; wraps modulo 2**WIDTH and produces no flags.
module pairincdec
    import regpairfile_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        case (pid_op_e'(op))
            PID_INC: dout = din + WIDTH'(1);
            PID_DEC: dout = din - WIDTH'(1);
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/regpairfile.sv
// Byte register file with two byte read ports, a pair read/write port, a pair
// inc/dec unit and a dedicated flag port; the last pair is PSW = {A, F}.
module regpairfile
    import regpairfile_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 3,
    parameter int REG_FLAG = default_flag(2 ** ADDRSIZE),
    parameter int REG_ACCU = default_accu(2 ** ADDRSIZE),
    parameter bit BYPASS   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wrenb,
    input  logic [ADDRSIZE-1:0]     waddr,
    input  logic [DATASIZE-1:0]     wdata,
    input  logic                    flenb,
    input  logic [DATASIZE-1:0]     ifdat,
    input  logic                    r1enb,
    input  logic [ADDRSIZE-1:0]     r1add,
    output logic [DATASIZE-1:0]     r1dat,
    input  logic                    r2enb,
    input  logic [ADDRSIZE-1:0]     r2add,
    output logic [DATASIZE-1:0]     r2dat,
    input  logic                    pwenb,
    input  logic [1:0]              pidop,
    input  logic [ADDRSIZE-2:0]     paddr,
    input  logic [2*DATASIZE-1:0]   pwdata,
    input  logic                    prenb,
    input  logic [ADDRSIZE-2:0]     pradd,
    output logic [2*DATASIZE-1:0]   prdat,
    output logic [DATASIZE-1:0]     ofdat
);

    localparam int REGCOUNT = 2 ** ADDRSIZE;
    localparam int PSW      = psw_pair(REGCOUNT);
    localparam int PW       = 2 * DATASIZE;

    logic [DATASIZE-1:0] regs [REGCOUNT];
    logic [DATASIZE-1:0] view [REGCOUNT];
    logic [ADDRSIZE-1:0] p_hi, p_lo, rd_hi, rd_lo;
    logic                id_act;
    logic [PW-1:0]       id_src, id_res;

    function automatic logic [ADDRSIZE-1:0] hi_idx(input logic [ADDRSIZE-2:0] p);
        if (int'(p) == PSW) return ADDRSIZE'(REG_ACCU);
        return {p, 1'b0};
    endfunction

    function automatic logic [ADDRSIZE-1:0] lo_idx(input logic [ADDRSIZE-2:0] p);
        if (int'(p) == PSW) return ADDRSIZE'(REG_FLAG);
        return {p, 1'b1};
    endfunction

    assign p_hi  = hi_idx(paddr);
    assign p_lo  = lo_idx(paddr);
    assign rd_hi = hi_idx(pradd);
    assign rd_lo = lo_idx(pradd);

    // A pair write in the same cycle cancels inc/dec entirely.
    assign id_act = !pwenb && (pidop == PID_INC || pidop == PID_DEC);
    assign id_src = {regs[p_hi], regs[p_lo]};

    pairincdec #(.WIDTH(PW)) u_incdec (
        .op   (pidop),
        .din  (id_src),
        .dout (id_res)
    );

    for (genvar i = 0; i < REGCOUNT; i++) begin : g_byte
        localparam logic [ADDRSIZE-1:0] IDX = ADDRSIZE'(i);
        logic [DATASIZE-1:0] d, q;

        // Priority: pair write > inc/dec > flag port > byte write.
        always_comb begin
            d = q;
            if (pwenb && p_hi == IDX)
                d = pwdata[PW-1:DATASIZE];
            else if (pwenb && p_lo == IDX)
                d = pwdata[DATASIZE-1:0];
            else if (id_act && p_hi == IDX)
                d = id_res[PW-1:DATASIZE];
            else if (id_act && p_lo == IDX)
                d = id_res[DATASIZE-1:0];
            else if (flenb && i == REG_FLAG)
                d = ifdat;
            else if (wrenb && waddr == IDX && i != REG_FLAG)
                d = wdata;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) q <= '0;
            else     q <= d;
        end

        assign regs[i] = q;
        // Forwarded view is suppressed under reset since those writes are lost.
        assign view[i] = (BYPASS && !rst) ? d : q;
    end

    assign r1dat = r1enb ? view[r1add] : '0;
    assign r2dat = r2enb ? view[r2add] : '0;
    assign prdat = prenb ? {view[rd_hi], view[rd_lo]} : '0;
    assign ofdat = regs[REG_FLAG];

endmodule

// File: tb/tb_regpairfile.sv
// Bench for regpairfile: one instance without and one with write bypass,
// sharing every input.
module tb_regpairfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrenb = 0, flenb = 0, r1enb = 0, r2enb = 0, pwenb = 0, prenb = 0;
    logic [2:0]  waddr = 0, r1add = 0, r2add = 0;
    logic [7:0]  wdata = 0, ifdat = 0;
    logic [1:0]  pidop = 0, paddr = 0, pradd = 0;
    logic [15:0] pwdata = 0;
    logic [7:0]  r1dat0, r2dat0, ofdat0, r1dat1, r2dat1, ofdat1;
    logic [15:0] prdat0, prdat1;

    int n_checks = 0;
    int n_errors = 0;
    logic [39:0] exp_q[$];

    always #5 clk = ~clk;

    regpairfile #(.BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .wrenb(wrenb), .waddr(waddr), .wdata(wdata),
        .flenb(flenb), .ifdat(ifdat), .r1enb(r1enb), .r1add(r1add), .r1dat(r1dat0),
        .r2enb(r2enb), .r2add(r2add), .r2dat(r2dat0), .pwenb(pwenb), .pidop(pidop),
        .paddr(paddr), .pwdata(pwdata), .prenb(prenb), .pradd(pradd), .prdat(prdat0),
        .ofdat(ofdat0)
    );

    regpairfile #(.BYPASS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .wrenb(wrenb), .waddr(waddr), .wdata(wdata),
        .flenb(flenb), .ifdat(ifdat), .r1enb(r1enb), .r1add(r1add), .r1dat(r1dat1),
        .r2enb(r2enb), .r2add(r2add), .r2dat(r2dat1), .pwenb(pwenb), .pidop(pidop),
        .paddr(paddr), .pwdata(pwdata), .prenb(prenb), .pradd(pradd), .prdat(prdat1),
        .ofdat(ofdat1)
    );

    typedef struct {
        logic we; logic [2:0] wa; logic [7:0] wd;
        logic fe; logic [7:0] fd;
        logic pe; logic [1:0] op; logic [1:0] pa; logic [15:0] pd;
        logic re; logic [2:0] a1; logic [2:0] a2; logic [1:0] ap;
        logic [7:0] e1; logic [7:0] e2; logic [15:0] ep; logic [7:0] ef;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_writes();
        wrenb = 0; flenb = 0; pwenb = 0; pidop = 2'b00;
    endtask

    // Drive one write cycle with reads set up, then compare after the edge.
    task automatic apply_vec(input vec_t v, input int idx);
        logic [39:0] e;
        @(negedge clk);
        wrenb = v.we; waddr = v.wa; wdata = v.wd;
        flenb = v.fe; ifdat = v.fd;
        pwenb = v.pe; pidop = v.op; paddr = v.pa; pwdata = v.pd;
        r1enb = v.re; r2enb = v.re; prenb = v.re;
        r1add = v.a1; r2add = v.a2; pradd = v.ap;
        exp_q.push_back({v.e1, v.e2, v.ep, v.ef});
        @(posedge clk);
        #1 clear_writes();
        #1;
        e = exp_q.pop_front();
        check($sformatf("vec%0d_nobyp", idx), {r1dat0, r2dat0, prdat0, ofdat0}, e);
        check($sformatf("vec%0d_byp", idx), {r1dat1, r2dat1, prdat1, ofdat1}, e);
    endtask

    initial begin
        // we wa wd  fe fd  pe op pa pd  re a1 a2 ap  e1 e2 ep ef
        vecs[0]  = '{1'b0,3'd0,8'h00, 1'b0,8'h00, 1'b1,2'b00,2'd2,16'hBEEF, 1'b1,3'd4,3'd5,2'd2, 8'hBE,8'hEF,16'hBEEF,8'h00};
        vecs[1]  = '{1'b0,3'd0,8'h00, 1'b0,8'h00, 1'b1,2'b00,2'd2,16'h00FF, 1'b1,3'd4,3'd5,2'd2, 8'h00,8'hFF,16'h00FF,8'h00};
        vecs[2]  = '{1'b0,3'd0,8'h00, 1'b0,8'h00, 1'b0,2'b01,2'd2,16'h0000, 1'b1,3'd4,3'd5,2'd2, 8'h01,8'h00,16'h0100,8'h00};
        vecs[3]  = '{1'b0,3'd0,8'h00, 1'b0,8'h00, 1'b1,2'b00,2'd2,16'hFFFF, 1'b1,3'd4,3'd5,2'd2, 8'hFF,8'hFF,16'hFFFF,8'h00};
        vecs[4]  = '{1'b0,3'd0,8'h00, 1'b0,8'h00, 1'b0,2'b01,2'd2,16'h0000, 1'b1,3'd4,3'd5,2'd2, 8'h00,8'h00,16'h0000,8'h00};
        vecs[5]  = '{1'b0,3'd0,8'h00, 1'b0,8'h00, 1'b0,2'b10,2'd0,16'h0000, 1'b1,3'd0,3'd1,2'd0, 8'hFF,8'hFF,16'hFFFF,8'h00};
        vecs[6]  = '{1'b1,3'd7,8'h3C, 1'b1,8'h81, 1'b0,2'b00,2'd0,16'h0000, 1'b1,3'd7,3'd6,2'd3, 8'h3C,8'h81,16'h3C81,8'h81};
        vecs[7]  = '{1'b1,3'd6,8'h55, 1'b0,8'h00, 1'b0,2'b00,2'd0,16'h0000, 1'b1,3'd7,3'd6,2'd3, 8'h3C,8'h81,16'h3C81,8'h81};
        vecs[8]  = '{1'b1,3'd0,8'h99, 1'b0,8'h00, 1'b1,2'b01,2'd0,16'h1122, 1'b1,3'd0,3'd1,2'd0, 8'h11,8'h22,16'h1122,8'h81};
        vecs[9]  = '{1'b1,3'd4,8'h77, 1'b1,8'h0F, 1'b1,2'b00,2'd1,16'h3344, 1'b1,3'd2,3'd4,2'd3, 8'h33,8'h77,16'h3C0F,8'h0F};
        vecs[10] = '{1'b1,3'd1,8'hAA, 1'b1,8'h5A, 1'b0,2'b10,2'd0,16'h0000, 1'b1,3'd1,3'd6,2'd0, 8'h21,8'h5A,16'h1121,8'h5A};
        vecs[11] = '{1'b0,3'd0,8'h00, 1'b0,8'h00, 1'b1,2'b00,2'd3,16'hA1B2, 1'b1,3'd7,3'd6,2'd3, 8'hA1,8'hB2,16'hA1B2,8'hB2};
        vecs[12] = '{1'b0,3'd0,8'h00, 1'b0,8'h00, 1'b0,2'b11,2'd2,16'h0000, 1'b1,3'd4,3'd5,2'd2, 8'h77,8'h00,16'h7700,8'hB2};
        vecs[13] = '{1'b0,3'd0,8'h00, 1'b0,8'h00, 1'b0,2'b01,2'd3,16'h0000, 1'b1,3'd7,3'd6,2'd3, 8'hA1,8'hB3,16'hA1B3,8'hB3};
        vecs[14] = '{1'b0,3'd0,8'h00, 1'b0,8'h00, 1'b0,2'b00,2'd0,16'h0000, 1'b0,3'd7,3'd6,2'd3, 8'h00,8'h00,16'h0000,8'hB3};

        // Reset state before any clock edge.
        r1enb = 1; r2enb = 1; prenb = 1; r1add = 3'd7; r2add = 3'd0; pradd = 2'd3;
        #2;
        check("reset_state", {r1dat0, r2dat0, prdat0, ofdat0}, 40'h0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 15; i++) apply_vec(vecs[i], i);

        // Same-cycle forwarding: byte write to A and inc of HL (7700 -> 7701).
        @(negedge clk);
        r1enb = 1; r2enb = 1; prenb = 1;
        wrenb = 1; waddr = 3'd7; wdata = 8'hA5; r1add = 3'd7;
        pidop = 2'b01; paddr = 2'd2; r2add = 3'd5; pradd = 2'd3;
        #1;
        check("byp0_old_a", {32'h0, r1dat0}, {32'h0, 8'hA1});
        check("byp1_new_a", {32'h0, r1dat1}, {32'h0, 8'hA5});
        check("byp1_psw", {24'h0, prdat1}, {24'h0, 16'hA5B3});
        check("byp0_old_l", {32'h0, r2dat0}, {32'h0, 8'h00});
        check("byp1_inc_l", {32'h0, r2dat1}, {32'h0, 8'h01});
        @(posedge clk);
        #1 clear_writes();
        #1;
        check("byp0_next_a", {32'h0, r1dat0}, {32'h0, 8'hA5});
        check("byp0_next_l", {32'h0, r2dat0}, {32'h0, 8'h01});

        // Back-to-back increments of HL advance once per cycle.
        @(negedge clk);
        pidop = 2'b01; paddr = 2'd2; pradd = 2'd2;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b_inc%0d", k), {24'h0, prdat0}, {24'h0, 16'h7701 + 16'(k)});
            check($sformatf("b2b_byp%0d", k), {24'h0, prdat1}, {24'h0, 16'h7702 + 16'(k)});
        end
        @(negedge clk);
        pidop = 2'b00;

        // A few random pair writes read back through the scoreboard.
        for (int k = 0; k < 4; k++) begin
            logic [15:0] rd;
            logic [1:0]  rp;
            rd = 16'($urandom_range(0, 65535));
            rp = 2'($urandom_range(0, 2));
            @(negedge clk);
            pwenb = 1; paddr = rp; pwdata = rd; pradd = rp;
            r1add = {rp, 1'b0}; r2add = {rp, 1'b1};
            exp_q.push_back({rd[15:8], rd[7:0], rd, 8'hB3});
            @(posedge clk);
            #1 clear_writes();
            #1;
            check($sformatf("rand%0d", k), {r1dat0, r2dat0, prdat0, ofdat0}, exp_q.pop_front());
        end

        // Reset mid-run clears everything immediately and drops same-cycle writes.
        @(negedge clk);
        wrenb = 1; waddr = 3'd0; wdata = 8'h12; flenb = 1; ifdat = 8'hD5;
        r1add = 3'd0; r2add = 3'd1; pradd = 2'd3;
        @(posedge clk);
        #1 clear_writes();
        #1;
        check("pre_rst_b", {32'h0, r1dat0}, {32'h0, 8'h12});
        check("pre_rst_f", {32'h0, ofdat0}, {32'h0, 8'hD5});
        @(negedge clk);
        #2 rst = 1; wrenb = 1; waddr = 3'd1; wdata = 8'h33;
        #1;
        check("rst_now0", {r1dat0, r2dat0, prdat0, ofdat0}, 40'h0);
        check("rst_now1", {r1dat1, r2dat1, prdat1, ofdat1}, 40'h0);
        @(posedge clk);
        #1;
        check("rst_edge0", {r1dat0, r2dat0, prdat0, ofdat0}, 40'h0);
        check("rst_edge1", {r1dat1, r2dat1, prdat1, ofdat1}, 40'h0);
        @(negedge clk);
        rst = 0; clear_writes();
        @(posedge clk);
        #1;
        check("post_rst0", {r1dat0, r2dat0, prdat0, ofdat0}, 40'h0);
        check("post_rst1", {r1dat1, r2dat1, prdat1, ofdat1}, 40'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
